// File: rtl/uart_pkg.sv
// Shared definitions for the UART register-access protocol: register map and command-byte encoding.
package uart_pkg;

  typedef logic [2:0] reg_rwaddr;

  localparam reg_rwaddr REG_CTRL     = 3'd0;
  localparam reg_rwaddr REG_STATUS   = 3'd1;
  localparam reg_rwaddr REG_DATA0    = 3'd2;
  localparam reg_rwaddr REG_DATA1    = 3'd3;
  localparam reg_rwaddr REG_IRQ_EN   = 3'd4;
  localparam reg_rwaddr REG_IRQ_STAT = 3'd5;
  localparam reg_rwaddr REG_SCRATCH  = 3'd6;
  localparam reg_rwaddr REG_ID       = 3'd7;

  // Command byte on the wire: upper nibble reserved as zero, then address, then the write flag.
  function automatic logic [7:0] uart_cmd_byte(input reg_rwaddr addr, input logic write);
    return {4'b0000, addr, write};
  endfunction

endpackage

// File: rtl/uart_timeout_counter.sv
// Read-reply watchdog: counts enabled cycles since the last clear and flags the last allowed cycle.
// Used by uart_cmd_initiator only when UART_CMD_TIMEOUT_EN is defined.
module uart_timeout_counter #(
  parameter int CYCLES = 100000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CW = $clog2(CYCLES);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Saturates at LAST so a stalled consumer never sees the count wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expired = i_enable && !i_clear && (cnt_q == LAST);

endmodule

// File: rtl/uart_cmd_initiator.sv
// Serialises single register read/write requests into UART command bytes and collects one-byte read replies.
// Tx bytes are held stable until i_tx_ready; the read-reply timeout exists only when UART_CMD_TIMEOUT_EN is defined.
module uart_cmd_initiator
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req_valid,
  output logic       o_req_ready,
  input  logic       i_req_write,
  input  reg_rwaddr  i_req_addr,
  input  logic [7:0] i_req_wdata,
  output logic       o_rsp_valid,
  output logic [7:0] o_rsp_data,
  output logic       o_rsp_timeout,
  output logic [7:0] o_tx_data,
  output logic       o_tx_data_valid,
  input  logic       i_tx_ready,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_data_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND_CMD,
    S_SEND_DATA,
    S_WAIT_RSP,
    S_DONE
  } state_e;

  state_e     state_q, state_d;
  logic       write_q, write_d;
  reg_rwaddr  addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic [7:0] rdata_q, rdata_d;
  logic       tmo_q, tmo_d;
  logic       ready_c;
  logic       expired;

`ifdef UART_CMD_TIMEOUT_EN
  uart_timeout_counter #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clear  (state_q != S_WAIT_RSP),
    .i_enable (state_q == S_WAIT_RSP),
    .o_expired(expired)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign expired = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    write_d         = write_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rdata_d         = rdata_q;
    tmo_d           = tmo_q;
    ready_c         = 1'b0;
    o_tx_data       = 8'h00;
    o_tx_data_valid = 1'b0;
    o_rsp_valid     = 1'b0;
    o_rsp_data      = 8'h00;
    o_rsp_timeout   = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (i_req_valid) begin
          write_d = i_req_write;
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          rdata_d = 8'h00;
          tmo_d   = 1'b0;
          state_d = S_SEND_CMD;
        end
      end
      S_SEND_CMD: begin
        o_tx_data       = uart_cmd_byte(addr_q, write_q);
        o_tx_data_valid = 1'b1;
        if (i_tx_ready) begin
          state_d = write_q ? S_SEND_DATA : S_WAIT_RSP;
        end
      end
      S_SEND_DATA: begin
        o_tx_data       = wdata_q;
        o_tx_data_valid = 1'b1;
        if (i_tx_ready) begin
          state_d = S_DONE;
        end
      end
      S_WAIT_RSP: begin
        // A reply landing on the expiry cycle still counts as a reply.
        if (i_rx_data_valid) begin
          rdata_d = i_rx_data;
          state_d = S_DONE;
        end else if (expired) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        o_rsp_valid   = 1'b1;
        o_rsp_data    = rdata_q;
        o_rsp_timeout = tmo_q;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_req_ready = ready_c & ~i_rst;

endmodule

// File: tb/tb_uart_cmd_initiator.sv
// Directed plus randomized bench for uart_cmd_initiator against a transaction-level reference model.
module tb_uart_cmd_initiator;

  localparam int T = 16;
`ifdef UART_CMD_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_write = 1'b0;
  logic [2:0] req_addr = 3'd0;
  logic [7:0] req_wdata = 8'h00;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;

  logic       req_ready, rsp_valid, rsp_timeout, tx_valid;
  logic [7:0] rsp_data, tx_data;

  int vectors = 0;
  int miscompares = 0;
  int tx_hs = 0;

  uart_cmd_initiator #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_write    (req_write),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_rsp_valid    (rsp_valid),
    .o_rsp_data     (rsp_data),
    .o_rsp_timeout  (rsp_timeout),
    .o_tx_data      (tx_data),
    .o_tx_data_valid(tx_valid),
    .i_tx_ready     (tx_ready),
    .i_rx_data      (rx_data),
    .i_rx_data_valid(rx_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_valid && tx_ready) tx_hs++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One complete request; stall < 0 picks a random per-byte transmitter stall.
  task automatic do_txn(input bit wr, input bit [2:0] a, input bit [7:0] wd,
                        input bit [7:0] rxd, input int rx_after, input int stall);
    bit [7:0] bytes[$];
    bit       timed_out;
    bit [7:0] exp_rsp;
    int       n;
    int       hs0;
    bytes.push_back(8'(int'(a) * 2 + int'(wr)));
    if (wr) bytes.push_back(wd);
    timed_out = !wr && TMO_EN && (rx_after >= T);
    exp_rsp   = (wr || timed_out) ? 8'h00 : rxd;
    hs0       = tx_hs;

    chk("req_ready_idle", req_ready, 1);
    chk("tx_valid_idle", tx_valid, 0);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
    step;
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = 3'($urandom); req_wdata = 8'($urandom);

    foreach (bytes[k]) begin
      n = (stall >= 0) ? stall : $urandom_range(0, 3);
      for (int s = 0; s <= n; s++) begin
        chk("tx_valid", tx_valid, 1);
        chk("tx_data", tx_data, bytes[k]);
        chk("req_ready_busy", req_ready, 0);
        tx_ready = (s == n);
        step;
      end
      tx_ready = 1'b0;
    end

    if (!wr) begin
      n = timed_out ? T : rx_after;
      for (int i = 0; i < n; i++) begin
        chk("wait_no_rsp", rsp_valid, 0);
        chk("wait_no_tx", tx_valid, 0);
        step;
      end
      if (!timed_out) begin
        rx_valid = 1'b1; rx_data = rxd;
        step;
        rx_valid = 1'b0; rx_data = 8'($urandom);
      end
    end

    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, exp_rsp);
    chk("rsp_timeout", rsp_timeout, timed_out);
    chk("tx_count", tx_hs - hs0, bytes.size());
    step;
    chk("rsp_pulse", rsp_valid, 0);
    chk("ready_after_rsp", req_ready, 1);
  endtask

  initial begin
    repeat (3) step;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", req_ready, 1);
    step;

    do_txn(1'b1, 3'd3, 8'hA5, 8'h00, 0, 0);
    do_txn(1'b0, 3'd5, 8'h00, 8'h3C, 9, 0);
    do_txn(1'b1, 3'd3, 8'h5A, 8'h00, 0, 7);
`ifdef UART_CMD_TIMEOUT_EN
    do_txn(1'b0, 3'd2, 8'h00, 8'h00, 1000, 0);
`endif
    do_txn(1'b0, 3'd6, 8'h00, 8'h55, T - 1, 0);

    rx_valid = 1'b1; rx_data = 8'hFF;
    step;
    rx_valid = 1'b0;
    step;
    do_txn(1'b0, 3'd0, 8'h00, 8'h12, 4, 0);

    req_valid = 1'b1; req_write = 1'b0; req_addr = 3'd1;
    step;
    req_valid = 1'b0; tx_ready = 1'b1;
    step;
    tx_ready = 1'b0;
    repeat (2) step;
    rst = 1'b1;
    step;
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_rsp_valid", rsp_valid, 0);
    chk("midrst_req_ready", req_ready, 0);
    rst = 1'b0;
    #1;
    chk("midrst_ready_release", req_ready, 1);
    step;
    chk("midrst_no_rsp", rsp_valid, 0);
    do_txn(1'b1, 3'd4, 8'hC3, 8'h00, 0, 1);

    for (int t = 0; t < 25; t++) begin
      do_txn(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), $urandom_range(0, 20), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_cmd_initiator.md
# uart_cmd_initiator

Host-side counterpart of the UART register-access protocol: accepts single register read/write requests from a local master and serialises them into command bytes for the UART transmitter. For reads it collects the one-byte reply from the UART receiver. It sits between a local controller (test sequencer or soft CPU bridge) and the uart_tx/uart_rx byte interfaces, driving a remote register file over the serial link.

## Interface
Parameters:
- TIMEOUT_CYCLES, 100000: clock cycles to wait for a read reply before aborting; must be ≥ 2.

Ports:
- i_clk  in  1  system clock
- i_rst  in  1  reset, synchronous, active-high
- i_req_valid  in  1  request present
- o_req_ready  out  1  initiator idle, can accept a request
- i_req_write  in  1  1 = write, 0 = read
- i_req_addr  in  3 (reg_rwaddr)  target register
- i_req_wdata  in  8  write data
- o_rsp_valid  out  1  one-cycle completion pulse
- o_rsp_data  out  8  read data; 0x00 for writes and timeouts
- o_rsp_timeout  out  1  qualifies o_rsp_valid: read aborted by timeout
- o_tx_data  out  8  byte to transmitter
- o_tx_data_valid  out  1  byte valid, held until accepted
- i_tx_ready  in  1  transmitter accepts byte when high with valid
- i_rx_data  in  8  byte from receiver
- i_rx_data_valid  in  1  one-cycle strobe, byte present

## Operation
- Command byte = {4'b0000, addr[2:0], write}. A write sends the command byte, then the data byte. A read sends the command byte, then waits for exactly one rx byte.
- FSM states: IDLE, SEND_CMD, SEND_DATA, WAIT_RSP, DONE.
  - IDLE: o_req_ready=1. On i_req_valid, latch write/addr/wdata → SEND_CMD.
  - SEND_CMD: o_tx_data = cmd byte, o_tx_data_valid=1. On i_tx_ready → SEND_DATA (write) or WAIT_RSP (read).
  - SEND_DATA: o_tx_data = latched wdata, valid=1. On i_tx_ready → DONE.
  - WAIT_RSP: on i_rx_data_valid, latch i_rx_data → DONE. On timeout → DONE with timeout flag.
  - DONE: o_rsp_valid=1 for one cycle → IDLE.
- o_tx_data_valid and o_tx_data are stable while waiting for i_tx_ready.
- rx bytes arriving outside WAIT_RSP are discarded; they are not buffered.
- Requests are ignored while o_req_ready=0. No queueing.
- Reset values: o_req_ready=0 during reset and 1 from the first cycle after it; o_rsp_valid=0, o_rsp_data=0x00, o_rsp_timeout=0, o_tx_data=0x00, o_tx_data_valid=0. The FSM state is IDLE.
- Reset mid-transaction: the FSM returns to IDLE and tx valid drops. A byte already accepted by the transmitter is not recalled. No response is issued.

## Timing
- Request accepted in cycle 0 (valid && ready). o_tx_data_valid rises in cycle 1.
- Zero-wait transmitter, write: cmd accepted in cycle 1, data in cycle 2, o_rsp_valid in cycle 3.
- Read: rx strobe in cycle M → o_rsp_valid with data in cycle M+1.
- Timeout counter clears on entry to WAIT_RSP and increments each cycle. At count TIMEOUT_CYCLES−1 without rx, the FSM moves to DONE with the timeout flag. Counter width is $clog2(TIMEOUT_CYCLES).
- An rx strobe in the same cycle as timeout expiry wins: data is returned and o_rsp_timeout=0.
- Earliest next request acceptance is the cycle after o_rsp_valid.

## Configuration
- UART_CMD_TIMEOUT_EN defined: timeout counter present, behaviour as above.
- UART_CMD_TIMEOUT_EN undefined: no counter; WAIT_RSP waits indefinitely and o_rsp_timeout is tied 0. TIMEOUT_CYCLES is unused.

## Structure
- The uart_pkg package holds reg_rwaddr, the register offsets, and a new function uart_cmd_byte(addr, write) that returns the command byte. The same function serves future encoder/decoder checks.
- The state enum stays local.
- One sub-module, uart_timeout_counter (clear, enable, expired). It is instantiated only under UART_CMD_TIMEOUT_EN.

## Test plan
- Write addr=3, wdata=0xA5, i_tx_ready always 1 → tx bytes 0x07 then 0xA5 in cycles 1–2. o_rsp_valid in cycle 3 with data 0x00 and timeout 0.
- Read addr=5, rx 0x3C injected 10 cycles after the cmd is accepted → tx byte 0x0A. o_rsp_valid one cycle after the rx strobe, o_rsp_data=0x3C.
- Write with i_tx_ready low for 7 cycles → o_tx_data=0x07 and valid held stable for all 8 cycles. Only 2 bytes are transferred in total.
- Timeout enabled, TIMEOUT_CYCLES=16, read with no reply → o_rsp_valid with o_rsp_timeout=1 and data 0x00, 16 cycles after entering WAIT_RSP. Repeat with rx 0x55 on the expiry cycle → data 0x55, timeout 0.
- Stray rx 0xFF in IDLE, then read addr=0 answered with 0x12 → response is 0x12, not 0xFF.
- i_rst asserted in WAIT_RSP → next cycle o_tx_data_valid=0, o_rsp_valid=0, o_req_ready=1 after reset release. The subsequent write completes normally.
